pipeline_fetch_ctrl: RTL and testbench

Fetch-side control and IF/ID boundary for the 5-stage pipeline. Consumes the fetch stage's current PC and the instruction-memory response, and holds the IF/ID pipeline register. Drives the fetch stage's PC enable, PC-select and redirect target. Resolves EX-stage branch redirects, ID-stage load-use stalls and multi-cycle instruction-memory waits.

---
 rtl/pipeline_pkg.sv | 7 +
 rtl/pipeline_fetch_ctrl_if.sv | 11 +
 rtl/pipeline_fetch_ctrl_load_use.sv | 11 +
 rtl/pipeline_fetch_ctrl.sv | 99 +++++++++
 tb/tb_pipeline_fetch_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants, fetch FSM encoding and register-field positions for the pipeline
package pipeline_pkg;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  typedef enum logic [1:0] {RUN = 2'd0, WAIT_IMEM = 2'd1, REDIR_PEND = 2'd2} state_t;
endpackage

// File: rtl/pipeline_fetch_ctrl_if.sv
// pipeline_fetch_ctrl_if: fetch-stage <-> fetch-control bundle (PC, imem response, PC enable/select/target)
interface pipeline_fetch_ctrl_if;
  logic [31:0] PC_out_IF;
  logic [31:0] inst_in;
  logic        imem_ready;
  logic        en_IF;
  logic        PCSrc;
  logic [31:0] PC_in_IF;
  modport master (output PC_out_IF, inst_in, imem_ready, input en_IF, PCSrc, PC_in_IF);
  modport slave (input PC_out_IF, inst_in, imem_ready, output en_IF, PCSrc, PC_in_IF);
endinterface

// File: rtl/pipeline_fetch_ctrl_load_use.sv
// load_use_detect: flags a load in ID/EX whose rd feeds rs1/rs2 of the valid IF/ID instruction
module load_use_detect (
  input  logic       i_valid,
  input  logic       i_mem_read,
  input  logic [4:0] i_rd,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  output logic       o_lu
);
  assign o_lu = i_valid & i_mem_read & (|i_rd) & ((i_rd == i_rs1) | (i_rd == i_rs2));
endmodule

// File: rtl/pipeline_fetch_ctrl.sv
// pipeline_fetch_ctrl: fetch control FSM (redirect > imem wait > load-use) plus the IF/ID register and stall/flush counters
module pipeline_fetch_ctrl #(
  parameter logic [31:0] NOP = pipeline_pkg::NOP
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_fetch_ctrl_if.slave         f,
  input  logic                         ex_branch_taken,
  input  logic [31:0]                  ex_target,
  input  logic                         id_ex_MemRead,
  input  logic [4:0]                   id_ex_rd,
  output logic [31:0]                  IF_ID_PC,
  output logic [31:0]                  IF_ID_inst,
  output logic                         IF_ID_valid,
  output logic                         ID_EX_flush,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt
);
  pipeline_pkg::state_t r_state, w_nxt;
  logic [31:0] r_pc, r_inst, r_pend, r_stall, r_flush;
  logic r_valid, w_lu, w_en, w_src, w_sel_ex, w_flush, w_bubble, w_load, w_pend_ld;
  load_use_detect u_lu (
    .i_valid(r_valid),
    .i_mem_read(id_ex_MemRead),
    .i_rd(id_ex_rd),
    .i_rs1(r_inst[pipeline_pkg::RS1_LSB +: 5]),
    .i_rs2(r_inst[pipeline_pkg::RS2_LSB +: 5]),
    .o_lu(w_lu)
  );
  // A pending redirect shares the redirect path: a new branch replaces the target, and
  // the redirect completes only once imem has answered for the current (stable) address.
  always_comb begin
    w_nxt = r_state;
    w_en = 1'b0;
    w_src = 1'b0;
    w_sel_ex = 1'b0;
    w_flush = 1'b0;
    w_bubble = 1'b0;
    w_load = 1'b0;
    w_pend_ld = 1'b0;
    if (r_state == pipeline_pkg::REDIR_PEND || ex_branch_taken) begin
      w_bubble = 1'b1;
      w_flush = ex_branch_taken;
      if (f.imem_ready) begin
        w_en = 1'b1;
        w_src = 1'b1;
        w_sel_ex = ex_branch_taken;
        w_nxt = pipeline_pkg::RUN;
      end else begin
        w_pend_ld = ex_branch_taken;
        w_nxt = pipeline_pkg::REDIR_PEND;
      end
    end else if (!f.imem_ready) begin
      w_bubble = 1'b1;
      w_nxt = pipeline_pkg::WAIT_IMEM;
    end else if (w_lu) begin
      w_flush = 1'b1;
      w_nxt = pipeline_pkg::RUN;
    end else begin
      w_en = 1'b1;
      w_load = 1'b1;
      w_nxt = pipeline_pkg::RUN;
    end
  end
  assign f.en_IF = w_en & rst_n;
  assign f.PCSrc = w_src & rst_n;
  assign f.PC_in_IF = w_sel_ex ? ex_target : r_pend;
  assign ID_EX_flush = w_flush & rst_n;
  assign IF_ID_PC = r_pc;
  assign IF_ID_inst = r_inst;
  assign IF_ID_valid = r_valid;
  assign stall_cnt = r_stall;
  assign flush_cnt = r_flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= pipeline_pkg::RUN;
      r_pc <= '0;
      r_inst <= NOP;
      r_valid <= 1'b0;
      r_pend <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_pend_ld) r_pend <= ex_target;
      if (w_bubble) begin
        r_pc <= f.PC_out_IF;
        r_inst <= NOP;
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_pc <= f.PC_out_IF;
        r_inst <= f.inst_in;
        r_valid <= 1'b1;
      end
      r_stall <= r_stall + {31'd0, ~w_en};
      r_flush <= r_flush + {31'd0, ex_branch_taken};
    end
  end
endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// tb_pipeline_fetch_ctrl: directed-vector bench for pipeline_fetch_ctrl
module tb_pipeline_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I0 = 32'h00100093;
  localparam logic [31:0] I1 = 32'h00200113;
  localparam logic [31:0] I2 = 32'h00728333;
  localparam logic [31:0] I3 = 32'h00528433;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ex_branch_taken, id_ex_MemRead;
  logic [31:0] ex_target;
  logic [4:0] id_ex_rd;
  logic [31:0] IF_ID_PC, IF_ID_inst, stall_cnt, flush_cnt;
  logic IF_ID_valid, ID_EX_flush;
  int vec = 0;
  int errs = 0;
  pipeline_fetch_ctrl_if fi ();
  pipeline_fetch_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .f(fi.slave),
    .ex_branch_taken(ex_branch_taken),
    .ex_target(ex_target),
    .id_ex_MemRead(id_ex_MemRead),
    .id_ex_rd(id_ex_rd),
    .IF_ID_PC(IF_ID_PC),
    .IF_ID_inst(IF_ID_inst),
    .IF_ID_valid(IF_ID_valid),
    .ID_EX_flush(ID_EX_flush),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic rdy, input logic [31:0] pc, input logic [31:0] inst, input logic br, input logic [31:0] tgt, input logic mr, input logic [4:0] rd);
    fi.imem_ready = rdy;
    fi.PC_out_IF = pc;
    fi.inst_in = inst;
    ex_branch_taken = br;
    ex_target = tgt;
    id_ex_MemRead = mr;
    id_ex_rd = rd;
  endtask
  task automatic test_reset;
    drive(1'b1, 32'h0, I0, 1'b0, 32'h0, 1'b0, 5'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush} !== 3'b000) begin errs++; $display("FAIL reset_comb: got %b want 000", {fi.en_IF, fi.PCSrc, ID_EX_flush}); end
    vec++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_valid} !== {32'h0, NOP, 1'b0}) begin errs++; $display("FAIL reset_ifid: got %h %h %b", IF_ID_PC, IF_ID_inst, IF_ID_valid); end
    vec++;
    if ({stall_cnt, flush_cnt} !== 64'h0) begin errs++; $display("FAIL reset_cnt: got %0d %0d want 0 0", stall_cnt, flush_cnt); end
    rst_n = 1'b1;
  endtask
  task automatic test_normal;
    logic [31:0] ins [3];
    ins[0] = I0;
    ins[1] = I1;
    ins[2] = I2;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(4 * i), ins[i], 1'b0, 32'h0, 1'b0, 5'd0);
      #4;
      vec++;
      if ({fi.en_IF, fi.PCSrc, ID_EX_flush} !== 3'b100) begin errs++; $display("FAIL normal_comb%0d: got %b want 100", i, {fi.en_IF, fi.PCSrc, ID_EX_flush}); end
      @(posedge clk);
      #1;
      vec++;
      if ({IF_ID_PC, IF_ID_inst, IF_ID_valid} !== {32'(4 * i), ins[i], 1'b1}) begin errs++; $display("FAIL normal_ifid%0d: got %h %h %b", i, IF_ID_PC, IF_ID_inst, IF_ID_valid); end
    end
  endtask
  task automatic test_load_use;
    drive(1'b1, 32'hC, I3, 1'b0, 32'h0, 1'b1, 5'd5);
    #4;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush} !== 3'b001) begin errs++; $display("FAIL lu_comb: got %b want 001", {fi.en_IF, fi.PCSrc, ID_EX_flush}); end
    @(posedge clk);
    #1;
    vec++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_valid} !== {32'h8, I2, 1'b1}) begin errs++; $display("FAIL lu_hold: got %h %h %b", IF_ID_PC, IF_ID_inst, IF_ID_valid); end
    vec++;
    if (stall_cnt !== 32'd1) begin errs++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
    drive(1'b1, 32'hC, I3, 1'b0, 32'h0, 1'b1, 5'd0);
    #4;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush} !== 3'b100) begin errs++; $display("FAIL lu_rd0_comb: got %b want 100", {fi.en_IF, fi.PCSrc, ID_EX_flush}); end
    @(posedge clk);
    #1;
    vec++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_valid, stall_cnt} !== {32'hC, I3, 1'b1, 32'd1}) begin errs++; $display("FAIL lu_rd0_ifid: got %h %h %b %0d", IF_ID_PC, IF_ID_inst, IF_ID_valid, stall_cnt); end
  endtask
  task automatic test_redirect_vs_lu;
    drive(1'b1, 32'h10, I0, 1'b1, 32'h40, 1'b1, 5'd5);
    #4;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush, fi.PC_in_IF} !== {3'b111, 32'h40}) begin errs++; $display("FAIL redir_lu_comb: got %b %h", {fi.en_IF, fi.PCSrc, ID_EX_flush}, fi.PC_in_IF); end
    @(posedge clk);
    #1;
    vec++;
    if ({IF_ID_inst, IF_ID_valid, stall_cnt, flush_cnt} !== {NOP, 1'b0, 32'd1, 32'd1}) begin errs++; $display("FAIL redir_lu_regs: got %h %b %0d %0d", IF_ID_inst, IF_ID_valid, stall_cnt, flush_cnt); end
  endtask
  task automatic test_branch;
    drive(1'b1, 32'h40, I1, 1'b1, 32'h100, 1'b0, 5'd0);
    #4;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush, fi.PC_in_IF} !== {3'b111, 32'h100}) begin errs++; $display("FAIL branch_comb: got %b %h", {fi.en_IF, fi.PCSrc, ID_EX_flush}, fi.PC_in_IF); end
    @(posedge clk);
    #1;
    vec++;
    if ({IF_ID_inst, IF_ID_valid, flush_cnt} !== {NOP, 1'b0, 32'd2}) begin errs++; $display("FAIL branch_regs: got %h %b %0d", IF_ID_inst, IF_ID_valid, flush_cnt); end
    drive(1'b1, 32'h100, I2, 1'b0, 32'h0, 1'b0, 5'd0);
    #4;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush} !== 3'b100) begin errs++; $display("FAIL branch_target_comb: got %b want 100", {fi.en_IF, fi.PCSrc, ID_EX_flush}); end
    @(posedge clk);
    #1;
    vec++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_valid} !== {32'h100, I2, 1'b1}) begin errs++; $display("FAIL branch_target_ifid: got %h %h %b", IF_ID_PC, IF_ID_inst, IF_ID_valid); end
  endtask
  task automatic test_imem_wait;
    drive(1'b0, 32'h104, I0, 1'b0, 32'h0, 1'b0, 5'd0);
    #4;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush} !== 3'b000) begin errs++; $display("FAIL wait1_comb: got %b want 000", {fi.en_IF, fi.PCSrc, ID_EX_flush}); end
    @(posedge clk);
    #1;
    vec++;
    if ({IF_ID_inst, IF_ID_valid} !== {NOP, 1'b0}) begin errs++; $display("FAIL wait1_ifid: got %h %b", IF_ID_inst, IF_ID_valid); end
    drive(1'b0, 32'h104, I0, 1'b1, 32'h200, 1'b0, 5'd0);
    #4;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush} !== 3'b001) begin errs++; $display("FAIL wait2_comb: got %b want 001", {fi.en_IF, fi.PCSrc, ID_EX_flush}); end
    @(posedge clk);
    #1;
    vec++;
    if (flush_cnt !== 32'd3) begin errs++; $display("FAIL wait2_flush_cnt: got %0d want 3", flush_cnt); end
    drive(1'b0, 32'h104, I0, 1'b0, 32'h0, 1'b0, 5'd0);
    #4;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush, fi.PC_in_IF} !== {3'b000, 32'h200}) begin errs++; $display("FAIL wait3_comb: got %b %h", {fi.en_IF, fi.PCSrc, ID_EX_flush}, fi.PC_in_IF); end
    @(posedge clk);
    #1;
    vec++;
    if (stall_cnt !== 32'd4) begin errs++; $display("FAIL wait3_stall_cnt: got %0d want 4", stall_cnt); end
    drive(1'b1, 32'h104, I3, 1'b0, 32'h0, 1'b0, 5'd0);
    #4;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush, fi.PC_in_IF} !== {3'b110, 32'h200}) begin errs++; $display("FAIL pend_redir_comb: got %b %h", {fi.en_IF, fi.PCSrc, ID_EX_flush}, fi.PC_in_IF); end
    @(posedge clk);
    #1;
    vec++;
    if ({IF_ID_inst, IF_ID_valid, stall_cnt, flush_cnt} !== {NOP, 1'b0, 32'd4, 32'd3}) begin errs++; $display("FAIL pend_redir_regs: got %h %b %0d %0d", IF_ID_inst, IF_ID_valid, stall_cnt, flush_cnt); end
    drive(1'b1, 32'h200, I0, 1'b0, 32'h0, 1'b0, 5'd0);
    #4;
    vec++;
    if ({fi.en_IF, fi.PCSrc} !== 2'b10) begin errs++; $display("FAIL after_pend_comb: got %b want 10", {fi.en_IF, fi.PCSrc}); end
    @(posedge clk);
    #1;
    vec++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_valid} !== {32'h200, I0, 1'b1}) begin errs++; $display("FAIL after_pend_ifid: got %h %h %b", IF_ID_PC, IF_ID_inst, IF_ID_valid); end
  endtask
  task automatic test_reset_in_pend;
    drive(1'b0, 32'h204, I1, 1'b1, 32'h300, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    vec++;
    if (flush_cnt !== 32'd4) begin errs++; $display("FAIL pend_entry_flush_cnt: got %0d want 4", flush_cnt); end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_valid, stall_cnt, flush_cnt} !== {32'h0, NOP, 1'b0, 64'h0}) begin errs++; $display("FAIL async_reset_regs: got %h %h %b %0d %0d", IF_ID_PC, IF_ID_inst, IF_ID_valid, stall_cnt, flush_cnt); end
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush} !== 3'b000) begin errs++; $display("FAIL async_reset_comb: got %b want 000", {fi.en_IF, fi.PCSrc, ID_EX_flush}); end
    rst_n = 1'b1;
    drive(1'b1, 32'h14, I1, 1'b0, 32'h0, 1'b0, 5'd0);
    #3;
    vec++;
    if ({fi.en_IF, fi.PCSrc, ID_EX_flush, fi.PC_in_IF} !== {3'b100, 32'h0}) begin errs++; $display("FAIL post_reset_comb: got %b %h", {fi.en_IF, fi.PCSrc, ID_EX_flush}, fi.PC_in_IF); end
    @(posedge clk);
    #1;
    vec++;
    if ({IF_ID_PC, IF_ID_inst, IF_ID_valid, stall_cnt} !== {32'h14, I1, 1'b1, 32'd0}) begin errs++; $display("FAIL post_reset_ifid: got %h %h %b %0d", IF_ID_PC, IF_ID_inst, IF_ID_valid, stall_cnt); end
  endtask
  initial begin
    test_reset;
    test_normal;
    test_load_use;
    test_redirect_vs_lu;
    test_branch;
    test_imem_wait;
    test_reset_in_pend;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
